// File: rtl/data_mem_arbiter_if.sv
// Request/response bundle for two requesters plus the single-port data memory port.
// slave = arbiter side, master = requesters and memory model side.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic              m0_err;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic              m1_err;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_read_data,
        output m0_ack, m0_err, m0_rdata,
        output m1_ack, m1_err, m1_rdata,
        output mem_address, mem_write_data, mem_write_enable
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_read_data,
        input  m0_ack, m0_err, m0_rdata,
        input  m1_ack, m1_err, m1_rdata,
        input  mem_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter/sequencer for a single-port synchronous data memory.
// Latency: grant in IDLE, memory drive next cycle, ack two cycles after grant; requesters hold req until ack.
module data_mem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MEM_BASE    = 64,
    parameter int MEM_TOP     = 127,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_arbiter_if.slave    bus
);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(MEM_BASE);
    localparam logic [ADDR_W-1:0] TOP_ADDR  = ADDR_W'(MEM_TOP);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              lat_id;
    logic              lat_we;
    logic              lat_ok;
    logic              pref;
    logic              rd_ok;
    logic              ack0;
    logic              ack1;
    logic              err0;
    logic              err1;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;

    logic              any_req;
    logic              grant_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_ok;

    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            grant_id = ROUND_ROBIN ? pref : 1'b0;
        end else begin
            grant_id = bus.m1_req;
        end
        sel_we    = grant_id ? bus.m1_we    : bus.m0_we;
        sel_addr  = grant_id ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = grant_id ? bus.m1_wdata : bus.m0_wdata;
        sel_ok    = (sel_addr >= BASE_ADDR) && (sel_addr <= TOP_ADDR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lat_id      <= 1'b0;
            lat_we      <= 1'b0;
            lat_ok      <= 1'b0;
            pref        <= 1'b0;
            rd_ok       <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_id      <= grant_id;
                        lat_we      <= sel_we;
                        lat_ok      <= sel_ok;
                        pref        <= ~grant_id;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        // Out-of-range writes turn into harmless reads.
                        mem_we_q    <= sel_we & sel_ok;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    ack0     <= ~lat_id;
                    ack1     <= lat_id;
                    err0     <= ~lat_id & ~lat_ok;
                    err1     <= lat_id & ~lat_ok;
                    rd_ok    <= ~lat_we & lat_ok;
                    state    <= RESP;
                end
                RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    rd_ok <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory read data arrives during RESP, so rdata is steered combinationally.
    assign bus.m0_ack           = ack0;
    assign bus.m1_ack           = ack1;
    assign bus.m0_err           = err0;
    assign bus.m1_err           = err1;
    assign bus.m0_rdata         = (ack0 && rd_ok) ? bus.mem_read_data : '0;
    assign bus.m1_rdata         = (ack1 && rd_ok) ? bus.mem_read_data : '0;
    assign bus.mem_address      = mem_addr_q;
    assign bus.mem_write_data   = mem_wdata_q;
    assign bus.mem_write_enable = mem_we_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: round-robin instance is scoreboarded, a fixed-priority twin
// sees the same requests and is checked on ack counts.
module tb_data_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_fp ();

    data_mem_arbiter #(.ROUND_ROBIN(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus));
    data_mem_arbiter #(.ROUND_ROBIN(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

    assign bus_fp.m0_req   = bus.m0_req;
    assign bus_fp.m0_we    = bus.m0_we;
    assign bus_fp.m0_addr  = bus.m0_addr;
    assign bus_fp.m0_wdata = bus.m0_wdata;
    assign bus_fp.m1_req   = bus.m1_req;
    assign bus_fp.m1_we    = bus.m1_we;
    assign bus_fp.m1_addr  = bus.m1_addr;
    assign bus_fp.m1_wdata = bus.m1_wdata;

    logic [7:0] mem_rr [256];
    logic [7:0] mem_fp [256];

    always @(posedge clk) begin
        if (bus.mem_write_enable) mem_rr[bus.mem_address] <= bus.mem_write_data;
        bus.mem_read_data <= mem_rr[bus.mem_address];
        if (bus_fp.mem_write_enable) mem_fp[bus_fp.mem_address] <= bus_fp.mem_write_data;
        bus_fp.mem_read_data <= mem_fp[bus_fp.mem_address];
    end

    typedef struct {
        logic       id;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   ack_times[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_acks = 0;
    int   fp0 = 0;
    int   fp1 = 0;
    bit   we_seen = 0;

    exp_t       mon_e;
    logic       mon_id;
    logic       mon_err;
    logic [7:0] mon_rdata;
    logic       lose_bad;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented ack pops one expectation; idle cycles must show zeroed responses.
    always @(negedge clk) begin
        if (bus.mem_write_enable) we_seen = 1'b1;
        if (bus_fp.m0_ack) fp0++;
        if (bus_fp.m1_ack) fp1++;
        if (rst_n) begin
            checks++;
            if (bus.m0_ack || bus.m1_ack) begin
                n_acks++;
                ack_times.push_back(cyc);
                mon_id    = bus.m1_ack;
                mon_err   = mon_id ? bus.m1_err : bus.m0_err;
                mon_rdata = mon_id ? bus.m1_rdata : bus.m0_rdata;
                lose_bad  = mon_id ? (bus.m0_err || bus.m0_rdata != 8'h00)
                                   : (bus.m1_err || bus.m1_rdata != 8'h00);
                if (bus.m0_ack && bus.m1_ack) begin
                    errors++;
                    $display("FAIL dual_ack got m0_ack=1 m1_ack=1 want one");
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack got id=%0d want no ack", mon_id);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_id != mon_e.id || mon_err != mon_e.err || mon_rdata != mon_e.rdata || lose_bad) begin
                        errors++;
                        $display("FAIL resp got id=%0d err=%0d rdata=%02h loser_bad=%0d want id=%0d err=%0d rdata=%02h loser_bad=0",
                                 mon_id, mon_err, mon_rdata, lose_bad, mon_e.id, mon_e.err, mon_e.rdata);
                    end
                end
            end else if (bus.m0_err || bus.m1_err || bus.m0_rdata != 8'h00 || bus.m1_rdata != 8'h00) begin
                errors++;
                $display("FAIL idle_resp got err=%0d/%0d rdata=%02h/%02h want 0", bus.m0_err, bus.m1_err,
                         bus.m0_rdata, bus.m1_rdata);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic set_req(input bit id, input bit on, input bit we, input logic [7:0] addr, input logic [7:0] wdata);
        if (id) begin
            bus.m1_req = on; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end else begin
            bus.m0_req = on; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end
    endtask

    // One transaction: expectation pushed, memory drive checked in ACCESS, ack expected two cycles after grant.
    task automatic txn(input bit id, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                       input bit xerr, input logic [7:0] xrdata);
        int lat;
        bit got;
        exp_t e;
        e.id = id; e.err = xerr; e.rdata = xrdata;
        sb.push_back(e);
        @(negedge clk);
        set_req(id, 1'b1, we, addr, wdata);
        lat = 0;
        got = 0;
        while (!got && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                check("access_we", int'(bus.mem_write_enable), int'(we && !xerr));
                check("access_addr", int'(bus.mem_address), int'(addr));
                if (we) check("access_wdata", int'(bus.mem_write_data), int'(wdata));
            end
            if (id ? bus.m1_ack : bus.m0_ack) begin
                got = 1;
                check("resp_we_low", int'(bus.mem_write_enable), 0);
            end
        end
        check("ack_latency", got ? lat : -1, 2);
        set_req(id, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    int base;
    int fp0_base;
    int fp1_base;
    int waited;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_rr[i] = 8'h00;
            mem_fp[i] = 8'h00;
        end
        bus.mem_read_data    = 8'h00;
        bus_fp.mem_read_data = 8'h00;
        set_req(1'b0, 1'b1, 1'b1, 8'd70, 8'hFF);
        set_req(1'b1, 1'b1, 1'b1, 8'd71, 8'hFF);

        // Reset with both requests asserted
        #32;
        check("rst_outputs", int'({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.m0_rdata, bus.m1_rdata,
                                   bus.mem_address, bus.mem_write_data, bus.mem_write_enable}), 0);
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        we_seen = 0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("idle_no_we", int'(we_seen), 0);

        // Write then read back
        txn(1'b0, 1'b1, 8'd70, 8'hA5, 1'b0, 8'h00);
        txn(1'b0, 1'b0, 8'd70, 8'h00, 1'b0, 8'hA5);

        // Preload; last grant m1 leaves m0 preferred
        txn(1'b0, 1'b1, 8'd80, 8'h3C, 1'b0, 8'h00);
        txn(1'b1, 1'b1, 8'd90, 8'hC3, 1'b0, 8'h00);

        // Contention: both held
        sb.push_back('{1'b0, 1'b0, 8'h3C});
        sb.push_back('{1'b1, 1'b0, 8'hC3});
        sb.push_back('{1'b0, 1'b0, 8'h3C});
        sb.push_back('{1'b1, 1'b0, 8'hC3});
        base = n_acks;
        fp0_base = fp0;
        fp1_base = fp1;
        ack_times.delete();
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 8'd80, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 8'd90, 8'h00);
        waited = 0;
        while (n_acks < base + 4 && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("rr_ack_count", n_acks - base, 4);
        for (int k = 1; k < 4; k++) begin
            check("rr_ack_spacing", (ack_times.size() > k) ? ack_times[k] - ack_times[k-1] : -1, 3);
        end
        check("fp_m0_acks", fp0 - fp0_base, 4);
        check("fp_m1_acks", fp1 - fp1_base, 0);
        repeat (2) @(negedge clk);

        // Range errors and boundaries
        we_seen = 0;
        txn(1'b1, 1'b1, 8'd10, 8'h55, 1'b1, 8'h00);
        txn(1'b1, 1'b1, 8'd128, 8'h66, 1'b1, 8'h00);
        check("err_no_we", int'(we_seen), 0);
        txn(1'b0, 1'b0, 8'd63, 8'h00, 1'b1, 8'h00);
        txn(1'b1, 1'b1, 8'd64, 8'h11, 1'b0, 8'h00);
        txn(1'b1, 1'b1, 8'd127, 8'h7F, 1'b0, 8'h00);
        txn(1'b1, 1'b0, 8'd64, 8'h00, 1'b0, 8'h11);
        txn(1'b0, 1'b0, 8'd127, 8'h00, 1'b0, 8'h7F);

        // Reset during ACCESS of an m1 write
        base = n_acks;
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b1, 8'd100, 8'h77);
        @(negedge clk);
        check("mid_access_we", int'(bus.mem_write_enable), 1);
        rst_n = 1'b0;
        #1;
        check("rst_we_drop", int'(bus.mem_write_enable), 0);
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("rst_no_ack", n_acks - base, 0);
        txn(1'b0, 1'b0, 8'd70, 8'h00, 1'b0, 8'hA5);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
